// File: rtl/adc_parallel_ctrl.sv
// Sequencing controller for the parallel-interface sound-localization ADC:
// two-word CONFIG_REG load, then triggered CONVST / BUSY / readout frames.
module adc_parallel_ctrl #(
   parameter int unsigned NUM_MICS = 4,
   parameter int unsigned T_CSWR   = 1,
   parameter int unsigned T_WRL    = 2,
   parameter int unsigned T_WRH    = 2,
   parameter int unsigned T_HDI    = 1,
   parameter int unsigned T_RDL    = 3,
   parameter int unsigned T_RDH    = 2,
   parameter int unsigned T_CONV   = 2,
   parameter int unsigned T_ACQ    = 8,
   parameter int unsigned BUSY_TMO = 1024
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cfg_start,
   input  logic [31:0] cfg_word,
   input  logic        conv_req,
   output logic        ctrl_ready,
   output logic [15:0] sample_data,
   output logic [2:0]  sample_ch,
   output logic        sample_valid,
   output logic        frame_done,
   output logic        err_timeout,
   output logic        err_overrun,
   output logic        CONVST_A,
   output logic        CONVST_B,
   output logic        CONVST_C,
   output logic        CONVST_D,
   input  logic        BUSY,
   output logic        CS_N,
   output logic        RD_N,
   output logic        WR_N,
   output logic [15:0] DB_OUT,
   output logic        DB_OE,
   input  logic [15:0] DB_IN
);

   function automatic int unsigned imax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   localparam int unsigned T_MAX = imax(imax(imax(T_CSWR, T_WRL), imax(T_WRH, T_HDI)),
                                        imax(imax(T_RDL, T_RDH), T_CONV));
   localparam int unsigned TW  = $clog2(T_MAX + 1);
   localparam int unsigned TOW = $clog2(BUSY_TMO + 1);
   localparam int unsigned AW  = $clog2(T_ACQ + 1);

   typedef enum logic [3:0] {
      IDLE, CFG_CS, CFG_WRL, CFG_HOLD, CFG_GAP, READY, CONV,
      WAIT_BH, WAIT_BL, RD_CS, RD_L, RD_H, ACQ
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   tcnt;
   logic [TOW-1:0]  tmo_cnt;
   logic [AW-1:0]   acq_cnt;
   logic [2:0]      ch;
   logic            word_sel, word_sel_nxt;
   logic [31:0]     cfg_lat, cfg_lat_nxt;
   logic [15:0]     db_nxt;
   logic            configured;
   logic            busy_m, busy_s;
   logic            cfg_go, tmo_hit, rd_last, last_ch, cfg_bus_nxt, rd_bus_nxt;

   assign rd_last = (state == RD_L) && (tcnt == TW'(T_RDL - 1));
   assign last_ch = (ch == 3'(NUM_MICS - 1));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      cfg_go       = 1'b0;
      tmo_hit      = 1'b0;
      word_sel_nxt = word_sel;
      unique case (state)
         IDLE: if (cfg_start) begin
            state_nxt    = CFG_CS;
            cfg_go       = 1'b1;
            word_sel_nxt = 1'b0;
         end
         READY: if (cfg_start) begin
            state_nxt    = CFG_CS;
            cfg_go       = 1'b1;
            word_sel_nxt = 1'b0;
         end else if (conv_req) begin
            state_nxt = CONV;
         end
         CFG_CS:   if (tcnt == TW'(T_CSWR - 1)) state_nxt = CFG_WRL;
         CFG_WRL:  if (tcnt == TW'(T_WRL - 1))  state_nxt = CFG_HOLD;
         CFG_HOLD: if (tcnt == TW'(T_HDI - 1))  state_nxt = CFG_GAP;
         CFG_GAP:  if (tcnt == TW'(T_WRH - 1)) begin
            if (word_sel) begin
               state_nxt = ACQ;
            end else begin
               state_nxt    = CFG_CS;
               word_sel_nxt = 1'b1;
            end
         end
         CONV: if (tcnt == TW'(T_CONV - 1)) state_nxt = WAIT_BH;
         // One timeout budget covers both the BUSY rise and the BUSY fall wait.
         WAIT_BH: if (busy_s) begin
            state_nxt = WAIT_BL;
         end else if (tmo_cnt == TOW'(BUSY_TMO - 1)) begin
            state_nxt = ACQ;
            tmo_hit   = 1'b1;
         end
         WAIT_BL: if (!busy_s) begin
            state_nxt = RD_CS;
         end else if (tmo_cnt == TOW'(BUSY_TMO - 1)) begin
            state_nxt = ACQ;
            tmo_hit   = 1'b1;
         end
         RD_CS: if (tcnt == TW'(T_CSWR - 1)) state_nxt = RD_L;
         RD_L:  if (rd_last) state_nxt = last_ch ? ACQ : RD_H;
         RD_H:  if (tcnt == TW'(T_RDH - 1)) state_nxt = RD_L;
         ACQ:   if (acq_cnt >= AW'(T_ACQ)) state_nxt = READY;
         default: state_nxt = IDLE;
      endcase
      cfg_lat_nxt = cfg_go ? cfg_word : cfg_lat;
      db_nxt      = word_sel_nxt ? cfg_lat_nxt[15:0] : cfg_lat_nxt[31:16];
      cfg_bus_nxt = state_nxt inside {CFG_CS, CFG_WRL, CFG_HOLD};
      rd_bus_nxt  = state_nxt inside {RD_CS, RD_L, RD_H};
   end

   // Strobes are registered decodes of the next state, so they line up with state.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tcnt         <= '0;
         tmo_cnt      <= '0;
         acq_cnt      <= '0;
         ch           <= '0;
         word_sel     <= 1'b0;
         cfg_lat      <= '0;
         configured   <= 1'b0;
         busy_m       <= 1'b0;
         busy_s       <= 1'b0;
         CS_N         <= 1'b1;
         RD_N         <= 1'b1;
         WR_N         <= 1'b1;
         DB_OE        <= 1'b0;
         DB_OUT       <= '0;
         CONVST_A     <= 1'b0;
         CONVST_B     <= 1'b0;
         CONVST_C     <= 1'b0;
         CONVST_D     <= 1'b0;
         ctrl_ready   <= 1'b0;
         sample_data  <= '0;
         sample_ch    <= '0;
         sample_valid <= 1'b0;
         frame_done   <= 1'b0;
         err_timeout  <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         busy_m   <= BUSY;
         busy_s   <= busy_m;
         word_sel <= word_sel_nxt;
         cfg_lat  <= cfg_lat_nxt;

         if (state_nxt != state)  tcnt <= '0;
         else if (tcnt != '1)     tcnt <= tcnt + 1'b1;

         if (state == CONV)                                     tmo_cnt <= '0;
         else if ((state == WAIT_BH) || (state == WAIT_BL))     tmo_cnt <= tmo_cnt + 1'b1;

         // Acquisition time runs from BUSY fall, the last CS_N rise of config, or a timeout.
         if (((state == CFG_HOLD) && (state_nxt == CFG_GAP) && word_sel) ||
             ((state == WAIT_BL) && (state_nxt == RD_CS)) || tmo_hit)
            acq_cnt <= AW'(1);
         else if (acq_cnt < AW'(T_ACQ))
            acq_cnt <= acq_cnt + 1'b1;

         if ((state == CFG_GAP) && (state_nxt == ACQ)) configured <= 1'b1;

         if ((state == WAIT_BL) && (state_nxt == RD_CS)) ch <= '0;
         else if (rd_last && !last_ch)                   ch <= ch + 1'b1;

         CS_N       <= !(cfg_bus_nxt || rd_bus_nxt);
         WR_N       <= (state_nxt != CFG_WRL);
         RD_N       <= (state_nxt != RD_L);
         DB_OE      <= cfg_bus_nxt;
         DB_OUT     <= cfg_bus_nxt ? db_nxt : '0;
         CONVST_A   <= (state_nxt == CONV);
         CONVST_B   <= (state_nxt == CONV);
         CONVST_C   <= (state_nxt == CONV);
         CONVST_D   <= (state_nxt == CONV);
         ctrl_ready <= (state_nxt == READY);

         sample_valid <= rd_last;
         frame_done   <= rd_last && last_ch;
         if (rd_last) begin
            sample_data <= DB_IN;
            sample_ch   <= ch;
         end

         if (cfg_go) begin
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
         end
         if (tmo_hit) err_timeout <= 1'b1;
         if (conv_req && configured && ((state != READY) || cfg_start)) err_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_parallel_ctrl.sv
// Self-checking bench for adc_parallel_ctrl: ADC bus model plus a sample scoreboard.
module tb_adc_parallel_ctrl;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        cfg_start;
   logic [31:0] cfg_word;
   logic        conv_req;
   logic        ctrl_ready;
   logic [15:0] sample_data;
   logic [2:0]  sample_ch;
   logic        sample_valid;
   logic        frame_done;
   logic        err_timeout;
   logic        err_overrun;
   logic        CONVST_A, CONVST_B, CONVST_C, CONVST_D;
   logic        BUSY = 1'b0;
   logic        CS_N, RD_N, WR_N;
   logic [15:0] DB_OUT;
   logic        DB_OE;
   logic [15:0] DB_IN = '0;

   int errors = 0;
   int checks = 0;

   adc_parallel_ctrl #(.NUM_MICS(4), .T_ACQ(8), .BUSY_TMO(1024)) dut (
      .CLK(CLK), .RST_N(RST_N), .cfg_start(cfg_start), .cfg_word(cfg_word),
      .conv_req(conv_req), .ctrl_ready(ctrl_ready), .sample_data(sample_data),
      .sample_ch(sample_ch), .sample_valid(sample_valid), .frame_done(frame_done),
      .err_timeout(err_timeout), .err_overrun(err_overrun),
      .CONVST_A(CONVST_A), .CONVST_B(CONVST_B), .CONVST_C(CONVST_C), .CONVST_D(CONVST_D),
      .BUSY(BUSY), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
      .DB_OUT(DB_OUT), .DB_OE(DB_OE), .DB_IN(DB_IN)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // ADC model: BUSY high 20 cycles after CONVST, DB_IN = base + read index.
   logic        busy_en = 1'b1;
   logic [15:0] db_base = 16'h1000;
   int          bcnt = 0;
   int          rd_idx = 0;
   logic        cv_q = 1'b0, rd_q = 1'b1;

   always @(posedge CLK) begin
      cv_q <= CONVST_A;
      rd_q <= RD_N;
      if (CONVST_A && !cv_q) begin
         bcnt   <= 22;
         rd_idx <= 0;
      end else begin
         if (bcnt > 0) bcnt <= bcnt - 1;
         if (!RD_N && rd_q) begin
            DB_IN  <= db_base + 16'(rd_idx);
            rd_idx <= rd_idx + 1;
         end
      end
      BUSY <= busy_en && (bcnt > 0) && (bcnt <= 20);
   end

   // Scoreboard entries: {frame_done, ch[2:0], data[15:0]}
   logic [19:0] exp_q[$];
   int cv_rises = 0, sv_cnt = 0, fd_cnt = 0;
   int rd_len = 0, rdh_len = 0, cv_len = 0;
   logic prev_rd = 1'b1, prev_cs = 1'b1, prev_cv = 1'b0, first_rd = 1'b1;

   task automatic push_frame(input logic [15:0] base, input int n);
      for (int j = 0; j < n; j++)
         exp_q.push_back({(j == 3), 3'(j), base + 16'(j)});
   endtask

   always @(negedge CLK) begin
      logic [19:0] e;
      if (!RST_N) begin
         prev_rd = 1'b1; prev_cs = 1'b1; prev_cv = 1'b0;
         first_rd = 1'b1; rd_len = 0; rdh_len = 0; cv_len = 0;
      end else begin
         if (!CS_N && prev_cs) begin
            first_rd = 1'b1;
            rdh_len  = 0;
         end
         if (!RD_N) begin
            if (prev_rd) begin
               if (!first_rd) check("rd_high_len", rdh_len, 2);
               first_rd = 1'b0;
               rd_len   = 0;
            end
            rd_len++;
         end else begin
            if (!prev_rd) begin
               check("rd_low_len", rd_len, 3);
               rdh_len = 0;
            end
            rdh_len++;
         end
         if (CONVST_A) begin
            if (!prev_cv) begin
               cv_rises++;
               cv_len = 0;
               check("convst_bcd", {CONVST_B, CONVST_C, CONVST_D}, 3'b111);
            end
            cv_len++;
         end else if (prev_cv) begin
            check("convst_len", cv_len, 2);
         end
         if (sample_valid) begin
            sv_cnt++;
            if (exp_q.size() == 0) begin
               check("sb_unexpected", sample_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("sample_data", sample_data, e[15:0]);
               check("sample_ch", sample_ch, e[18:16]);
               check("frame_done", frame_done, e[19]);
            end
         end else if (frame_done) begin
            check("fd_orphan", frame_done, 0);
         end
         if (frame_done) fd_cnt++;
         prev_rd = RD_N; prev_cs = CS_N; prev_cv = CONVST_A;
      end
   end

   task automatic pulse_conv;
      conv_req = 1'b1;
      @(negedge CLK);
      conv_req = 1'b0;
   endtask

   task automatic wait_ready(input int budget, input string tag);
      for (int i = 0; i < budget && !ctrl_ready; i++) @(negedge CLK);
      check(tag, ctrl_ready, 1);
   endtask

   task automatic wait_read(input int idx, input string tag);
      for (int i = 0; i < 400 && !(!RD_N && rd_idx == idx); i++) @(negedge CLK);
      check(tag, (!RD_N && rd_idx == idx), 1);
   endtask

   task automatic load_cfg(input logic [31:0] w);
      cfg_word  = w;
      cfg_start = 1'b1;
      @(negedge CLK);
      cfg_start = 1'b0;
   endtask

   initial begin
      int cv0, sv0, fd0, n, m, pulses, cs_words, db_bad, wr_len, last_cs_rise, ready_cyc;
      logic pcs, pwr;
      logic [15:0] w;

      RST_N = 1'b0; cfg_start = 1'b0; conv_req = 1'b0; cfg_word = '0;
      repeat (3) @(negedge CLK);
      check("rst_cs_n", CS_N, 1);
      check("rst_rd_n", RD_N, 1);
      check("rst_wr_n", WR_N, 1);
      check("rst_convst", {CONVST_A, CONVST_B, CONVST_C, CONVST_D}, 4'b0000);
      check("rst_db", {DB_OE, DB_OUT}, 17'h0);
      check("rst_flags", {ctrl_ready, sample_valid, frame_done, err_timeout, err_overrun}, 5'b0);
      RST_N = 1'b1;
      repeat (2) @(negedge CLK);

      // Unconfigured controller ignores conversion requests.
      cv0 = cv_rises;
      pulse_conv();
      repeat (10) @(negedge CLK);
      check("unconf_convst", cv_rises - cv0, 0);
      check("unconf_errs", {err_overrun, err_timeout}, 2'b00);
      check("unconf_ready", ctrl_ready, 0);

      // Config load with bus timing observed cycle by cycle.
      cfg_word = 32'hA005_3FF0;
      cfg_start = 1'b1;
      pulses = 0; cs_words = 0; db_bad = 0; wr_len = 0;
      last_cs_rise = -1; ready_cyc = -1; pcs = 1'b1; pwr = 1'b1;
      for (int i = 0; i < 100 && ready_cyc < 0; i++) begin
         @(negedge CLK);
         cfg_start = 1'b0;
         if (!CS_N && pcs) cs_words++;
         if (!WR_N) wr_len++;
         if (WR_N && !pwr) begin
            check("cfg_wrl_len", wr_len, 2);
            wr_len = 0;
            pulses++;
         end
         if (!CS_N) begin
            w = (cs_words == 1) ? 16'hA005 : 16'h3FF0;
            if (!DB_OE || DB_OUT !== w) db_bad++;
         end
         if (CS_N && !pcs) last_cs_rise = i;
         if (ctrl_ready) ready_cyc = i;
         pcs = CS_N; pwr = WR_N;
      end
      check("cfg_wr_pulses", pulses, 2);
      check("cfg_cs_words", cs_words, 2);
      check("cfg_db_stable", db_bad, 0);
      check("cfg_ready_delay", ready_cyc - last_cs_rise, 8);

      // Normal frame.
      db_base = 16'h1000;
      push_frame(db_base, 4);
      cv0 = cv_rises; sv0 = sv_cnt; fd0 = fd_cnt;
      pulse_conv();
      wait_ready(300, "frame_ready");
      repeat (2) @(negedge CLK);
      check("frame_samples", sv_cnt - sv0, 4);
      check("frame_done_cnt", fd_cnt - fd0, 1);
      check("frame_convst", cv_rises - cv0, 1);

      // conv_req during RD_L of channel 1 is dropped and flagged.
      push_frame(db_base, 4);
      cv0 = cv_rises; sv0 = sv_cnt;
      pulse_conv();
      wait_read(2, "ovr_reach_ch1");
      pulse_conv();
      wait_ready(300, "ovr_ready");
      repeat (30) @(negedge CLK);
      check("ovr_flag", err_overrun, 1);
      check("ovr_samples", sv_cnt - sv0, 4);
      check("ovr_convst", cv_rises - cv0, 1);

      // BUSY never rises: timeout after 1024 wait cycles.
      busy_en = 1'b0;
      sv0 = sv_cnt; fd0 = fd_cnt;
      pulse_conv();
      n = 1;
      while (n < 1300 && !err_timeout) begin
         @(negedge CLK);
         n++;
      end
      check("tmo_latency", n, 1027);
      m = n;
      while (m < 1400 && !ctrl_ready) begin
         @(negedge CLK);
         m++;
      end
      check("tmo_acq", m - n, 8);
      check("tmo_samples", sv_cnt - sv0, 0);
      check("tmo_frame_done", fd_cnt - fd0, 0);
      busy_en = 1'b1;
      load_cfg(32'hA005_3FF0);
      check("tmo_clear", err_timeout, 0);
      check("ovr_clear", err_overrun, 0);
      wait_ready(100, "recfg_ready");

      // Reset during RD_L of channel 2.
      push_frame(db_base, 2);
      pulse_conv();
      wait_read(3, "rst_reach_ch2");
      #1 RST_N = 1'b0;
      #1;
      check("midrst_strobes", {RD_N, CS_N, CONVST_A}, 3'b110);
      check("midrst_valid", sample_valid, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      cv0 = cv_rises;
      pulse_conv();
      repeat (20) @(negedge CLK);
      check("midrst_unconf_convst", cv_rises - cv0, 0);
      check("midrst_unconf_ready", ctrl_ready, 0);
      check("midrst_unconf_ovr", err_overrun, 0);

      // Fresh config and a frame with a different data pattern.
      load_cfg(32'h1234_ABCD);
      wait_ready(100, "final_cfg_ready");
      db_base = 16'h2A50;
      push_frame(db_base, 4);
      sv0 = sv_cnt;
      pulse_conv();
      wait_ready(300, "final_frame_ready");
      repeat (2) @(negedge CLK);
      check("final_samples", sv_cnt - sv0, 4);
      check("sb_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
